// File: rtl/pulse_train_gen.sv
// Burst pulse generator: emits i_cnt pulses of HIGH_LEN high / LOW_LEN low cycles,
// then a one-cycle o_done strobe. i_abort ends a burst early without o_done.
module pulse_train_gen #(
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned TMR_WIDTH = 8,
    parameter int unsigned HIGH_LEN  = 20,
    parameter int unsigned LOW_LEN   = 20
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_cnt,
    input  logic                 i_abort,
    output logic                 o_pulse,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_remain
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    localparam logic [TMR_WIDTH-1:0] HIGH_LAST = TMR_WIDTH'(HIGH_LEN);
    localparam logic [TMR_WIDTH-1:0] LOW_LAST  = TMR_WIDTH'(LOW_LEN);
    localparam logic [TMR_WIDTH-1:0] TMR_ONE   = TMR_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [TMR_WIDTH-1:0]   timer_q, timer_d;
    logic                   pulse_d, busy_d, done_d;
    logic [CNT_WIDTH-1:0]   remain_d;

    // State and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            o_pulse  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_remain <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            o_pulse  <= pulse_d;
            o_busy   <= busy_d;
            o_done   <= done_d;
            o_remain <= remain_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pulse_d  = o_pulse;
        busy_d   = o_busy;
        done_d   = 1'b0;
        remain_d = o_remain;

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    remain_d = i_cnt;
                    if (i_cnt != '0) begin
                        state_d = S_HIGH;
                        pulse_d = 1'b1;
                        busy_d  = 1'b1;
                        timer_d = TMR_ONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_HIGH: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                    timer_d = '0;
                end else if (timer_q == HIGH_LAST) begin
                    state_d = S_LOW;
                    pulse_d = 1'b0;
                    timer_d = TMR_ONE;
                    // Count a pulse only once its high phase has fully completed
                    if (o_remain != '0) begin
                        remain_d = o_remain - CNT_WIDTH'(1);
                    end
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end

            S_LOW: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    timer_d = '0;
                end else if (timer_q == LOW_LAST) begin
                    if (o_remain != '0) begin
                        state_d = S_HIGH;
                        pulse_d = 1'b1;
                        timer_d = TMR_ONE;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
                timer_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Randomized scoreboard bench for pulse_train_gen: bursts are queued as expectations
// and a negedge monitor checks every output cycle against an arithmetic burst model.
module tb_pulse_train_gen;

    localparam int unsigned CW = 8;
    localparam int unsigned TW = 8;
    localparam int          HL = 20;
    localparam int          LL = 20;
    localparam int          P  = HL + LL;

    logic          i_clk   = 1'b0;
    logic          i_rst   = 1'b1;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [CW-1:0] i_cnt   = '0;
    logic          o_pulse;
    logic          o_busy;
    logic          o_done;
    logic [CW-1:0] o_remain;

    // s: accepting edge index, n: pulse count, a: edge index (relative) where abort lands, -1 none
    typedef struct {
        int s;
        int n;
        int a;
    } exp_t;

    exp_t q[$];
    int   cyc         = 0;
    int   n_cmp       = 0;
    int   n_bad       = 0;
    int   idle_remain = 0;

    pulse_train_gen #(
        .CNT_WIDTH(CW),
        .TMR_WIDTH(TW),
        .HIGH_LEN (HL),
        .LOW_LEN  (LL)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_cnt   (i_cnt),
        .i_abort (i_abort),
        .o_pulse (o_pulse),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_remain(o_remain)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Pulses still outstanding k cycles after the start edge
    function automatic int rem_at(input int n, input int k);
        int c;
        if (k < HL) c = 0;
        else        c = (k - HL) / P + 1;
        if (c > n) c = n;
        return n - c;
    endfunction

    task automatic check(input string name, input logic [CW+2:0] got, input logic [CW+2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: pulse/busy/done/remain got %b/%b/%b/%0d required %b/%b/%b/%0d",
                     name, cyc, got[CW+2], got[CW+1], got[CW], got[CW-1:0],
                     exp[CW+2], exp[CW+1], exp[CW], exp[CW-1:0]);
        end
    endtask

    // Monitor: compares every cycle against the burst at the head of the queue
    always @(negedge i_clk) begin
        int   k, n, a, er;
        logic ep, eb, ed;
        if (i_rst) begin
            q.delete();
            idle_remain = 0;
        end else if (q.size() == 0 || cyc < q[0].s) begin
            check("idle", {o_pulse, o_busy, o_done, o_remain}, {3'b000, CW'(idle_remain)});
        end else begin
            k  = cyc - q[0].s;
            n  = q[0].n;
            a  = q[0].a;
            ep = 1'b0;
            eb = 1'b0;
            ed = 1'b0;
            er = 0;
            if (a >= 0 && k >= a) begin
                er = rem_at(n, a - 1);
                idle_remain = er;
                void'(q.pop_front());
            end else if (k < n * P) begin
                ep = ((k % P) < HL);
                eb = 1'b1;
                er = rem_at(n, k);
            end else if (k == n * P + 1) begin
                ed = 1'b1;
                idle_remain = 0;
                void'(q.pop_front());
            end
            check("burst", {o_pulse, o_busy, o_done, o_remain}, {ep, eb, ed, CW'(er)});
        end
    end

    // Issue one burst; optional abort edge, ignored mid-burst start, ignored start in DONE
    task automatic run_burst(input int n, input int a, input int ign_k, input bit start_in_done);
        int s, k, guard;
        @(posedge i_clk);
        #1;
        i_start = 1'b1;
        i_cnt   = CW'(n);
        s       = cyc + 1;
        q.push_back('{s, n, a});
        guard = 0;
        do begin
            @(posedge i_clk);
            #1;
            k = cyc - s;
            guard++;
            i_start = (k == ign_k) || (start_in_done && k == n * P);
            i_cnt   = (k == ign_k) ? CW'(9) : CW'($urandom);
            i_abort = (a >= 0 && k == a - 1);
        end while (q.size() != 0 && guard < n * P + 20);
        i_start = 1'b0;
        i_abort = 1'b0;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL timeout n=%0d: burst not finished after %0d cycles, required done by %0d",
                     n, guard, n * P + 2);
            q.delete();
        end
    endtask

    initial begin
        int n, a, ig;
        #1;
        check("reset", {o_pulse, o_busy, o_done, o_remain}, '0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        run_burst(3, -1, -1, 1'b0);
        run_burst(0, -1, -1, 1'b1);
        run_burst(2, -1, 30, 1'b1);
        run_burst(4, P + 10, -1, 1'b0);
        run_burst(4, -1, -1, 1'b0);

        // Abort and start together in IDLE: nothing must happen
        @(posedge i_clk);
        #1;
        i_start = 1'b1;
        i_abort = 1'b1;
        i_cnt   = CW'(5);
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_abort = 1'b0;
        repeat (3) @(posedge i_clk);

        // Asynchronous reset in the middle of a high phase
        @(posedge i_clk);
        #1;
        i_start = 1'b1;
        i_cnt   = CW'(3);
        q.push_back('{cyc + 1, 3, -1});
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (5) @(posedge i_clk);
        #3;
        check("pre_reset", {o_pulse, o_busy, o_done, o_remain}, {3'b110, CW'(3)});
        i_rst = 1'b1;
        #1;
        check("reset_mid_high", {o_pulse, o_busy, o_done, o_remain}, '0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        run_burst(1, -1, -1, 1'b0);

        for (int i = 0; i < 14; i++) begin
            n  = int'($urandom_range(1, 5));
            a  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n * P)) : -1;
            ig = int'($urandom_range(0, n * P - 1));
            run_burst(n, a, ig, 1'($urandom_range(0, 1)));
        end

        run_burst(255, -1, 100, 1'b0);
        repeat (4) @(posedge i_clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
